// File: rtl/ntt_out_collector.sv
// NTT1024 output collector: captures the interleaved coefficient stream and replays it in natural order.
// Define NTT_OUT_REDUCE_EN to add the final conditional subtraction (x >= q ? x - q : x) on the output path.
module ntt_out_collector #(
    parameter int DATA_W    = 32,
    parameter int MAX_DEPTH = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        ring_depth,
    input  logic [DATA_W-1:0] q,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              coll_done,
    output logic              err
);
    localparam int         AW    = MAX_DEPTH;
    localparam logic [3:0] MAX_D = 4'(MAX_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [AW-1:0]     n_last_reg;
    logic [AW-1:0]     half_reg;
    logic [AW-1:0]     wr_cnt_reg;
    logic [AW-1:0]     rd_cnt_reg;
    logic              rd_done_reg;
    logic              err_reg;
    logic              coll_done_reg;

    logic              pipe_valid_reg;
    logic              pipe_last_reg;
    logic [DATA_W-1:0] ram_q_reg;
    logic              skid_valid_reg;
    logic              skid_last_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic [DATA_W-1:0] out_data_reg;

    logic              depth_ok;
    logic              start_acc;
    logic              wr_en;
    logic              drain_end;
    logic              err_set;
    logic              pop;
    logic              issue;
    logic [1:0]        occ;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] ram_word;

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    assign depth_ok = (ring_depth >= 4'd2) && (ring_depth <= MAX_D);
    assign pop      = out_valid_reg && out_ready;

    // Even stream positions fill the lower half, odd positions the upper half.
    assign wr_addr = wr_cnt_reg[0] ? ((wr_cnt_reg >> 1) + half_reg) : (wr_cnt_reg >> 1);

    always_comb begin
        state_next = state_reg;
        start_acc  = 1'b0;
        wr_en      = 1'b0;
        drain_end  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && depth_ok) begin
                    start_acc  = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt_reg == n_last_reg) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last_reg) begin
                    drain_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A word arriving alongside an accepted start is silently dropped.
    assign err_set = (start && ((state_reg != IDLE) || !depth_ok)) ||
                     (in_valid && ((state_reg == DRAIN) || ((state_reg == IDLE) && !start_acc)));

    // Credit check: a read is only launched if its data is guaranteed a slot in out/skid.
    assign occ   = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, pipe_valid_reg};
    assign issue = (state_reg == DRAIN) && !rd_done_reg &&
                   ({1'b0, occ} < (3'd2 + {2'b0, pop}));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
        ram_q_reg <= mem[rd_cnt_reg];
    end

`ifdef NTT_OUT_REDUCE_EN
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else if (start_acc) begin
            q_reg <= q;
        end
    end

    assign ram_word = (ram_q_reg >= q_reg) ? (ram_q_reg - q_reg) : ram_q_reg;
`else
    logic unused_q;

    assign unused_q = ^q;
    assign ram_word = ram_q_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            n_last_reg     <= '0;
            half_reg       <= '0;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
            rd_done_reg    <= 1'b0;
            err_reg        <= 1'b0;
            coll_done_reg  <= 1'b0;
            pipe_valid_reg <= 1'b0;
            pipe_last_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_last_reg  <= 1'b0;
            skid_data_reg  <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            coll_done_reg <= drain_end;

            if (start_acc) begin
                n_last_reg  <= AW'((32'd1 << ring_depth) - 32'd1);
                half_reg    <= AW'(32'd1 << (ring_depth - 4'd1));
                wr_cnt_reg  <= '0;
                rd_cnt_reg  <= '0;
                rd_done_reg <= 1'b0;
                err_reg     <= 1'b0;
            end else if (err_set) begin
                err_reg <= 1'b1;
            end

            if (wr_en) begin
                wr_cnt_reg <= wr_cnt_reg + AW'(1);
            end

            pipe_valid_reg <= issue;
            if (issue) begin
                pipe_last_reg <= (rd_cnt_reg == n_last_reg);
                if (rd_cnt_reg == n_last_reg) begin
                    rd_done_reg <= 1'b1;
                end else begin
                    rd_cnt_reg <= rd_cnt_reg + AW'(1);
                end
            end

            // Output register refills from skid first, then from the RAM pipe.
            if (!out_valid_reg || pop) begin
                if (skid_valid_reg) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= skid_data_reg;
                    out_last_reg  <= skid_last_reg;
                    if (pipe_valid_reg) begin
                        skid_data_reg <= ram_word;
                        skid_last_reg <= pipe_last_reg;
                    end else begin
                        skid_valid_reg <= 1'b0;
                    end
                end else if (pipe_valid_reg) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= ram_word;
                    out_last_reg  <= pipe_last_reg;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (pipe_valid_reg) begin
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= ram_word;
                skid_last_reg  <= pipe_last_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg != IDLE);
    assign coll_done = coll_done_reg;
    assign err       = err_reg;

endmodule

// File: doc/ntt_out_collector.md
# ntt_out_collector

Downstream collector for the NTT1024 core. Captures the coefficient stream the core emits after `done`, in which even and odd stream positions carry the lower and upper half of the polynomial. Stores the stream in an internal buffer and replays it in natural index order over a valid/ready stream. Optionally applies the final conditional subtraction that brings each coefficient into [0, q).

## Interface
- `DATA_W`, 32, coefficient/word width
- `MAX_DEPTH`, 10, log2 of largest ring (buffer = 2^MAX_DEPTH words)
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse, driven from the NTT core's `done`; arms capture
- `ring_depth`  in  4  log2(N); sampled on accepted `start`
- `q`  in  DATA_W  modulus; sampled on accepted `start`
- `in_valid`  in  1  capture strobe for `in_data`
- `in_data`  in  DATA_W  coefficient from core `dout0`
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  sink accepts word
- `out_data`  out  DATA_W  coefficient, natural order
- `out_last`  out  1  high with index N-1
- `busy`  out  1  high in CAPTURE or DRAIN
- `coll_done`  out  1  one-cycle pulse after last word accepted
- `err`  out  1  sticky protocol error; cleared on accepted `start`

## Operation
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE: `start` accepted only if 2 <= `ring_depth` <= `MAX_DEPTH`; latch N = 1<<ring_depth, q; clear counters and `err`; go CAPTURE. Out-of-range depth: stay IDLE, set `err`.
- CAPTURE: write counter m, 0..N-1, increments per `in_valid`. Address = m[0]==0 ? m>>1 : (m>>1)+N/2. Gaps (in_valid low) of any length allowed. After word m=N-1: go DRAIN.
- DRAIN: read counter r, 0..N-1, read buffer at r; present `out_data`; advance on `out_valid && out_ready`. After word N-1 accepted: pulse `coll_done`, go IDLE.
- `in_valid` in IDLE or DRAIN: word ignored, `err` set. `start` in CAPTURE or DRAIN: ignored, `err` set.
- Buffer: single-port-write/single-port-read synchronous RAM, 1-cycle read latency, hidden by a 2-entry prefetch/skid so throughput is 1 word/cycle.
- Reset (any state, including mid-capture/drain): state IDLE, counters 0, buffer contents don't-care, all outputs 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `coll_done`=0, `err`=0.
- `busy` rises the cycle after accepted `start`; first capturable `in_valid` is the cycle after `start`. The same-cycle `in_valid` is ignored, and `err` is not set.
- Last capture write at edge E; `out_valid` first high at E+2 (RAM read + register).
- `out_data`/`out_last` held stable while `out_valid && !out_ready`.
- With `out_ready` held high: N consecutive output cycles, no bubbles.
- `coll_done` is high the cycle after the last handshake; `busy` falls in the same cycle.
- `in_valid` on the final capture cycle and DRAIN entry do not overlap; a word arriving the cycle after m=N-1 is flagged as an error.

## Configuration
- `NTT_OUT_REDUCE_EN` defined: the output stage computes `out_data` = (x >= q) ? x - q : x, with one subtraction, registered before output; latency unchanged. Inputs >= 2q get one subtraction only.
- Undefined: `out_data` = stored word unchanged; no comparator or subtractor instantiated.

## Test plan
- N=256 (ring_depth=8), q=7681, in_data=m for m=0..255, out_ready=1: out_data[i]=2i for i<128, 2(i-128)+1 for i>=128; `out_last` at i=255; `coll_done` 1 cycle later.
- N=256, q=7681, REDUCE_EN: in_data=7681+m for m<256: out_data equals the ramp case above; without macro, out_data = 7681 + same.
- Backpressure: N=16, out_ready toggled 1/0 pseudo-randomly; every word is delivered once, in order, and held stable while stalled.
- Bursty capture: N=1024, in_valid in bursts of 32 separated by 1-cycle gaps (matching the 16-PE core burst size); output order is correct and there are no extra words.
- Errors: ring_depth=1 or 11 at start -> stay IDLE, `err`=1; `in_valid` in IDLE -> `err`=1; next valid start clears `err`.
- Reset mid-DRAIN after 50 of 256 words: the next cycle has all outputs 0 and the FSM in IDLE; a fresh capture then completes correctly.
